// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: shared definitions for the NEC IR receiver.
// Contents: FSM state encoding, duration windows in sub-ticks (1/8 NEC unit),
// the saturating timeout count, error cause codes and small decode helpers.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_ACT = 3'd1,
    ST_START_GAP = 3'd2,
    ST_BIT_ACT   = 3'd3,
    ST_BIT_GAP   = 3'd4,
    ST_STOP_ACT  = 3'd5
  } nec_state_e;

  // Phase windows, inclusive, in sub-ticks.
  localparam logic [7:0] START_ACT_MIN = 8'd112;
  localparam logic [7:0] START_ACT_MAX = 8'd144;
  localparam logic [7:0] START_GAP_MIN = 8'd48;
  localparam logic [7:0] START_GAP_MAX = 8'd80;
  localparam logic [7:0] BURST_MIN     = 8'd4;
  localparam logic [7:0] BURST_MAX     = 8'd12;
  localparam logic [7:0] GAP0_MIN      = 8'd4;
  localparam logic [7:0] GAP0_MAX      = 8'd12;
  localparam logic [7:0] GAP1_MIN      = 8'd20;
  localparam logic [7:0] GAP1_MAX      = 8'd28;
  // Start bursts shorter than this are treated as line glitches, not errors.
  localparam logic [7:0] GLITCH_MIN    = 8'd4;
  // Saturation value of the duration counter; reaching it mid-frame is a timeout.
  localparam logic [7:0] DUR_TIMEOUT   = 8'd255;

  localparam logic [5:0] FRAME_BITS    = 6'd32;

  localparam logic [1:0] ERR_TIMING    = 2'd0;
  localparam logic [1:0] ERR_ADDR      = 2'd1;
  localparam logic [1:0] ERR_DATA      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  function automatic logic in_window(input logic [7:0] cnt,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

  // True when inv is the bitwise complement of val (NEC byte checksum).
  function automatic logic is_complement(input logic [7:0] inv,
                                         input logic [7:0] val);
    return (inv == ~val);
  endfunction

endpackage

// File: rtl/nec_ir_tick.sv
// nec_ir_tick: prescaler plus saturating phase-duration counter.
// Ports:
//   clk, rst : clock, async active-high reset
//   clr      : clears prescaler and counter (phase edge or receiver disabled)
//   div      : prescaler terminal count, sub-tick period = div+1 clk
//   tick     : high in the cycle the prescaler is at terminal count
//   count    : sub-ticks since the last clear, saturating at 255
module nec_ir_tick
  import nec_ir_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick,
  output logic [7:0]  count
);

  logic [15:0] pre_r;

  // >= so that lowering div below the running prescaler value cannot stall it.
  assign tick = (pre_r >= div);

  // Prescaler and duration counter; clear has priority over a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= 16'd0;
      count <= 8'd0;
    end else if (clr) begin
      pre_r <= 16'd0;
      count <= 8'd0;
    end else if (tick) begin
      pre_r <= 16'd0;
      if (count != DUR_TIMEOUT) begin
        count <= count + 8'd1;
      end
    end else begin
      pre_r <= pre_r + 16'd1;
    end
  end

endmodule

// File: rtl/nec_ir_rx.sv
// nec_ir_rx: NEC infrared frame receiver.
// Ports:
//   clk, rst            : clock, async active-high reset
//   cfg_en              : receiver enable (0 forces IDLE, outputs hold)
//   cfg_pol             : active (burst) level of ir_in
//   cfg_div             : sub-tick divider, sub-tick = cfg_div+1 clk = 1/8 NEC unit
//   ir_in               : raw asynchronous IR line
//   rx_valid            : one-cycle pulse, frame decoded; rx_addr/rx_data updated
//   rx_addr, rx_data    : last good frame
//   rx_err              : one-cycle pulse, frame aborted
//   rx_err_code         : cause of last error (timing/addr/data/timeout)
// A raw ir_in transition sampled at clock edge N acts on the FSM at edge N+3:
// two synchroniser stages, then one registered level stage feeding the edge compare.
module nec_ir_rx
  import nec_ir_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic        cfg_pol,
  input  logic [15:0] cfg_div,
  input  logic        ir_in,
  output logic        rx_valid,
  output logic [7:0]  rx_addr,
  output logic [7:0]  rx_data,
  output logic        rx_err,
  output logic [1:0]  rx_err_code
);

  logic        sync_r;
  logic        ir_s;
  logic        act_s;
  logic        act_r;
  logic        act_d_r;
  logic        edge_s;
  logic        tick_s;
  logic [7:0]  dur_s;
  logic        timeout_s;
  logic        burst_ok_s;
  logic        gap0_s;
  logic        gap1_s;

  nec_state_e  state_r, state_n;
  logic [31:0] sr_r, sr_n;
  logic [5:0]  idx_r, idx_n;
  logic        valid_n;
  logic        err_n;
  logic [1:0]  code_n;
  logic [7:0]  addr_n;
  logic [7:0]  data_n;

  // Synchroniser, active-level register and its delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r  <= 1'b0;
      ir_s    <= 1'b0;
      act_r   <= 1'b0;
      act_d_r <= 1'b0;
    end else begin
      sync_r  <= ir_in;
      ir_s    <= sync_r;
      act_r   <= act_s;
      act_d_r <= act_r;
    end
  end

  assign act_s  = (ir_s == cfg_pol);
  assign edge_s = act_r ^ act_d_r;

  nec_ir_tick u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (edge_s | ~cfg_en),
    .div   (cfg_div),
    .tick  (tick_s),
    .count (dur_s)
  );

  // Fire in the same cycle the counter saturates, unless an edge clears it.
  assign timeout_s  = (dur_s == DUR_TIMEOUT) ||
                      ((dur_s == (DUR_TIMEOUT - 8'd1)) && tick_s && !edge_s);
  assign burst_ok_s = in_window(dur_s, BURST_MIN, BURST_MAX);
  assign gap0_s     = in_window(dur_s, GAP0_MIN, GAP0_MAX);
  assign gap1_s     = in_window(dur_s, GAP1_MIN, GAP1_MAX);

  // Next-state, shift register and output decode; every phase ends on an edge.
  always_comb begin
    state_n = state_r;
    sr_n    = sr_r;
    idx_n   = idx_r;
    valid_n = 1'b0;
    err_n   = 1'b0;
    code_n  = rx_err_code;
    addr_n  = rx_addr;
    data_n  = rx_data;
    if (!cfg_en) begin
      state_n = ST_IDLE;
    end else if ((state_r != ST_IDLE) && timeout_s) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
      code_n  = ERR_TIMEOUT;
    end else if (edge_s) begin
      case (state_r)
        ST_IDLE: begin
          // Only an active-going edge can open a frame.
          if (act_r) state_n = ST_START_ACT;
          else       state_n = ST_IDLE;
        end
        ST_START_ACT: begin
          if (in_window(dur_s, START_ACT_MIN, START_ACT_MAX)) begin
            state_n = ST_START_GAP;
          end else if (dur_s < GLITCH_MIN) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMING;
          end
        end
        ST_START_GAP: begin
          if (in_window(dur_s, START_GAP_MIN, START_GAP_MAX)) begin
            state_n = ST_BIT_ACT;
            idx_n   = 6'd0;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMING;
          end
        end
        ST_BIT_ACT: begin
          if (burst_ok_s) begin
            state_n = ST_BIT_GAP;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMING;
          end
        end
        ST_BIT_GAP: begin
          if (gap0_s || gap1_s) begin
            // LSB first: after 32 shifts the first bit sits at sr[0].
            sr_n  = {gap1_s, sr_r[31:1]};
            idx_n = idx_r + 6'd1;
            if (idx_n == FRAME_BITS) state_n = ST_STOP_ACT;
            else                     state_n = ST_BIT_ACT;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMING;
          end
        end
        ST_STOP_ACT: begin
          state_n = ST_IDLE;
          if (!burst_ok_s) begin
            err_n  = 1'b1;
            code_n = ERR_TIMING;
          end else if (!is_complement(sr_r[15:8], sr_r[7:0])) begin
            err_n  = 1'b1;
            code_n = ERR_ADDR;
          end else if (!is_complement(sr_r[31:24], sr_r[23:16])) begin
            err_n  = 1'b1;
            code_n = ERR_DATA;
          end else begin
            valid_n = 1'b1;
            addr_n  = sr_r[7:0];
            data_n  = sr_r[23:16];
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // FSM state, frame shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sr_r        <= 32'd0;
      idx_r       <= 6'd0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= 2'd0;
      rx_addr     <= 8'd0;
      rx_data     <= 8'd0;
    end else begin
      state_r     <= state_n;
      sr_r        <= sr_n;
      idx_r       <= idx_n;
      rx_valid    <= valid_n;
      rx_err      <= err_n;
      rx_err_code <= code_n;
      rx_addr     <= addr_n;
      rx_data     <= data_n;
    end
  end

endmodule
